// File: rtl/lcd_link_arbiter.sv
// lcd_link_arbiter
// ----------------
// Shares one byte-wide LCD SPI driver between host command bytes and
// framebuffer line dumps read from the double-banked line RAM. A grant is
// either one command byte or one whole line (LINE_PIXELS 16-bit pixels sent
// high byte first), so a pixel stream is never interleaved with a command.
// The two requesters alternate when both are waiting; one line request can be
// queued while the link is busy with something else.
//
// Ports
//   clk_i, rst_i           system clock, synchronous active-high reset
//   cmd_valid_i/_data_i    command byte offer ([7:0] byte, [8] dcx)
//   cmd_ready_o            command accepted when cmd_valid_i && cmd_ready_o
//   dump_start_i/_bank_i   one-cycle line dump request and bank to dump
//   dump_busy_o            a dump is pending, running or just finishing
//   dump_done_o            one-cycle pulse after the last byte of a line
//   line_ram_raddr_o       line RAM read address (data valid one cycle later)
//   line_ram_read_data_i   line RAM read data
//   lcd_data_in_o/_dcx_o   byte and dcx presented to the SPI driver
//   lcd_start_o            one-cycle start pulse to the SPI driver
//   lcd_done_i             one-cycle pulse from the driver when a byte is done
module lcd_link_arbiter #(
    parameter int LINE_PIXELS = 240,
    parameter int BANK1_BASE  = 240
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    input  logic [8:0]  cmd_data_i,
    output logic        cmd_ready_o,
    input  logic        dump_start_i,
    input  logic        dump_bank_i,
    output logic        dump_busy_o,
    output logic        dump_done_o,
    output logic [8:0]  line_ram_raddr_o,
    input  logic [15:0] line_ram_read_data_i,
    output logic [7:0]  lcd_data_in_o,
    output logic        lcd_data_dcx_o,
    output logic        lcd_start_o,
    input  logic        lcd_done_i
);

    localparam logic [8:0] BANK1_ADDR = 9'(BANK1_BASE);
    localparam logic [8:0] LAST_IDX   = 9'(LINE_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD_WAIT,
        PIX_ADDR,
        PIX_READ,
        PIX_HI,
        PIX_HI_WAIT,
        PIX_LO,
        PIX_LO_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic        bank_q, bank_d;
    logic [8:0]  idx_q, idx_d;
    logic        last_q, last_d;       // 0: command went last, 1: dump went last
    logic [15:0] pix_q, pix_d;
    logic [7:0]  data_q, data_d;
    logic        dcx_q, dcx_d;
    logic        done_q, done_d;

    logic        in_pix;
    logic [8:0]  bank_base;

    assign in_pix    = (state_q != IDLE) && (state_q != CMD_WAIT);
    assign bank_base = bank_q ? BANK1_ADDR : 9'd0;

    // A waiting line only blocks commands when the command side went last.
    assign cmd_ready_o = (state_q == IDLE) && !(pend_q && !last_q);
    // dump_done cycle still counts as busy, so a request coinciding with the
    // completion pulse is dropped rather than silently queued.
    assign dump_busy_o      = pend_q || in_pix || done_q;
    assign dump_done_o      = done_q;
    assign line_ram_raddr_o = in_pix ? bank_base + idx_q : 9'd0;

    // The driver byte/dcx are registered, but the start cycle shows the new
    // value combinationally so a command goes out in its handshake cycle.
    assign lcd_data_in_o  = data_d;
    assign lcd_data_dcx_o = dcx_d;

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d     = state_q;
        pend_d      = pend_q;
        bank_d      = bank_q;
        idx_d       = idx_q;
        last_d      = last_q;
        pix_d       = pix_q;
        data_d      = data_q;
        dcx_d       = dcx_q;
        done_d      = 1'b0;
        lcd_start_o = 1'b0;

        if (dump_start_i && !dump_busy_o) begin
            pend_d = 1'b1;
            bank_d = dump_bank_i;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    lcd_start_o = 1'b1;
                    data_d      = cmd_data_i[7:0];
                    dcx_d       = cmd_data_i[8];
                    last_d      = 1'b0;
                    state_d     = CMD_WAIT;
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    idx_d   = 9'd0;
                    last_d  = 1'b1;
                    state_d = PIX_ADDR;
                end
            end
            CMD_WAIT: begin
                if (lcd_done_i) state_d = IDLE;
            end
            PIX_ADDR: state_d = PIX_READ;
            PIX_READ: begin
                pix_d   = line_ram_read_data_i;
                state_d = PIX_HI;
            end
            PIX_HI: begin
                lcd_start_o = 1'b1;
                data_d      = pix_q[15:8];
                dcx_d       = 1'b1;
                state_d     = PIX_HI_WAIT;
            end
            PIX_HI_WAIT: begin
                if (lcd_done_i) state_d = PIX_LO;
            end
            PIX_LO: begin
                lcd_start_o = 1'b1;
                data_d      = pix_q[7:0];
                dcx_d       = 1'b1;
                state_d     = PIX_LO_WAIT;
            end
            PIX_LO_WAIT: begin
                if (lcd_done_i) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 9'd1;
                        state_d = PIX_ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            bank_q  <= 1'b0;
            idx_q   <= 9'd0;
            last_q  <= 1'b1;
            pix_q   <= 16'd0;
            data_q  <= 8'd0;
            dcx_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            bank_q  <= bank_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            pix_q   <= pix_d;
            data_q  <= data_d;
            dcx_q   <= dcx_d;
            done_q  <= done_d;
        end
    end

endmodule
